// File: rtl/reaction_fsm.sv
// Reaction-time game controller: random 1..2 s wait, then a microsecond BCD
// stopwatch that records the last and the best reaction time.
module reaction_fsm #(
   parameter int TICKS_PER_US = 25,
   parameter int US_PER_MS    = 1000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_btn,
   input  logic        i_bcdmux,
   output logic [2:0]  o_dst,
   output logic [23:0] o_bcd,
   output logic        o_lit,
   output logic        o_miss,
   output logic        o_init
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'b000,
      ST_READY = 3'b001,
      ST_GO    = 3'b010,
      ST_MISS  = 3'b011,
      ST_HIT   = 3'b110
   } state_t;

   localparam logic [7:0]  PRESC_MAX = 8'(TICKS_PER_US - 1);
   localparam logic [9:0]  US_MAX    = 10'(US_PER_MS - 1);
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [23:0] TIMER_MAX = 24'h999999;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
   endfunction

   function automatic logic [23:0] bcd_inc(input logic [23:0] v);
      logic [23:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (c) begin
            if (r[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   state_t      state_r;
   logic        sync1_r, sync2_r, prev_r;
   logic [1:0]  prime_r;
   logic [15:0] lfsr_r;
   logic [7:0]  presc_r;
   logic [9:0]  us_r;
   logic [10:0] delay_r;
   logic [23:0] timer_r, last_r, best_r;
   logic        lit_r, miss_r, init_r;

   logic        press_s, tick_us_s, tick_ms_s;
   logic [10:0] delay_load_s;

   assign press_s      = sync2_r & ~prev_r;
   assign tick_us_s    = (presc_r == PRESC_MAX);
   assign tick_ms_s    = tick_us_s && (us_r == US_MAX);
   assign delay_load_s = 11'd1000 + {1'b0, lfsr_r[9:0]};

   assign o_dst  = state_r;
   assign o_lit  = lit_r;
   assign o_miss = miss_r;
   assign o_init = init_r;
   assign o_bcd  = i_bcdmux ? best_r : last_r;

   // Button synchronizer, edge history and free-running LFSR.
   // The edge history starts high and only tracks once the synchronizer is
   // filled, so a button held through reset release never reads as a press.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         prev_r  <= 1'b1;
         prime_r <= 2'b00;
         lfsr_r  <= LFSR_SEED;
      end else begin
         sync1_r <= i_btn;
         sync2_r <= sync1_r;
         prime_r <= {prime_r[0], 1'b1};
         if (prime_r[1]) begin
            prev_r <= sync2_r;
         end else begin
            prev_r <= 1'b1;
         end
         lfsr_r <= lfsr_step(lfsr_r);
      end
   end

   // Game FSM with timebase, delay counter, stopwatch and result registers.
   // Every transition restarts the timebase so ticks are aligned to entry.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
         presc_r <= 8'd0;
         us_r    <= 10'd0;
         delay_r <= 11'd0;
         timer_r <= 24'h000000;
         last_r  <= 24'h000000;
         best_r  <= 24'h000000;
         lit_r   <= 1'b0;
         miss_r  <= 1'b0;
         init_r  <= 1'b1;
      end else begin
         presc_r <= tick_us_s ? 8'd0 : presc_r + 8'd1;
         if (tick_ms_s) begin
            us_r <= 10'd0;
         end else if (tick_us_s) begin
            us_r <= us_r + 10'd1;
         end else begin
            us_r <= us_r;
         end

         case (state_r)
            ST_IDLE: begin
               if (press_s) begin
                  state_r <= ST_READY;
                  delay_r <= delay_load_s;
                  presc_r <= 8'd0;
                  us_r    <= 10'd0;
               end
            end

            ST_READY: begin
               if (press_s) begin
                  state_r <= ST_MISS;
                  miss_r  <= 1'b1;
                  presc_r <= 8'd0;
                  us_r    <= 10'd0;
               end else if (tick_ms_s && (delay_r == 11'd1)) begin
                  state_r <= ST_GO;
                  lit_r   <= 1'b1;
                  timer_r <= 24'h000000;
                  presc_r <= 8'd0;
                  us_r    <= 10'd0;
               end else if (tick_ms_s) begin
                  delay_r <= delay_r - 11'd1;
               end
            end

            ST_GO: begin
               if (press_s) begin
                  state_r <= ST_HIT;
                  lit_r   <= 1'b0;
                  last_r  <= timer_r;
                  if (init_r || (timer_r < best_r)) begin
                     best_r <= timer_r;
                  end
                  init_r  <= 1'b0;
                  presc_r <= 8'd0;
                  us_r    <= 10'd0;
               end else if (tick_us_s && (timer_r == TIMER_MAX)) begin
                  state_r <= ST_MISS;
                  lit_r   <= 1'b0;
                  miss_r  <= 1'b1;
                  presc_r <= 8'd0;
                  us_r    <= 10'd0;
               end else if (tick_us_s) begin
                  timer_r <= bcd_inc(timer_r);
               end
            end

            ST_MISS, ST_HIT: begin
               if (press_s) begin
                  state_r <= ST_READY;
                  miss_r  <= 1'b0;
                  delay_r <= delay_load_s;
                  presc_r <= 8'd0;
                  us_r    <= 10'd0;
               end
            end

            default: begin
               state_r <= ST_IDLE;
               lit_r   <= 1'b0;
               miss_r  <= 1'b0;
               presc_r <= 8'd0;
               us_r    <= 10'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reaction_fsm.sv
// Scoreboard bench for reaction_fsm: a game-level model predicts each display
// transition (cycle and outputs); a monitor checks transitions and steady outputs.
module tb_reaction_fsm;

   localparam int T = 2;
   localparam int U = 4;
   localparam logic [2:0] D_IDLE  = 3'b000;
   localparam logic [2:0] D_READY = 3'b001;
   localparam logic [2:0] D_GO    = 3'b010;
   localparam logic [2:0] D_MISS  = 3'b011;
   localparam logic [2:0] D_HIT   = 3'b110;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        btn = 1'b0;
   logic        bcdmux = 1'b0;
   logic [2:0]  dst;
   logic [23:0] bcd;
   logic        lit, miss, init;

   reaction_fsm #(.TICKS_PER_US(T), .US_PER_MS(U)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn), .i_bcdmux(bcdmux),
      .o_dst(dst), .o_bcd(bcd), .o_lit(lit), .o_miss(miss), .o_init(init)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [2:0]  dst;
      logic        lit;
      logic        miss;
      logic        init;
      logic [23:0] last;
      logic [23:0] best;
   } exp_t;

   exp_t        q[$];
   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc;
   logic [15:0] m_lfsr;
   logic [2:0]  m_dst = D_IDLE;
   logic [23:0] m_last = 24'h0;
   logic [23:0] m_best = 24'h0;
   logic        m_init = 1'b1;
   int          m_go = 0;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [23:0] to_bcd(input int n);
      logic [23:0] r;
      int          k;
      k = n;
      for (int i = 0; i < 6; i++) begin
         r[i*4 +: 4] = 4'(k % 10);
         k = k / 10;
      end
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_bad++;
         if (n_bad <= 20) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   // Edge count since reset release and the LFSR sequence as the spec defines it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc    <= 0;
         m_lfsr <= 16'hACE1;
      end else begin
         cyc    <= cyc + 1;
         m_lfsr <= lfsr_next(m_lfsr);
      end
   end

   // Monitor: pops an expectation on every display-state change, checks outputs each cycle.
   exp_t       cur = '{0, 3'b000, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0};
   logic [2:0] prev_dst = 3'b000;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         cur      = '{0, 3'b000, 1'b0, 1'b0, 1'b1, 24'h0, 24'h0};
         prev_dst = 3'b000;
      end else if (dst !== prev_dst) begin
         if (q.size() == 0) begin
            check("unexpected_transition", {29'd0, dst}, {29'd0, prev_dst});
         end else begin
            e = q.pop_front();
            check("transition_cycle", cyc, e.cyc);
            cur = e;
         end
         prev_dst = dst;
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
         e = q.pop_front();
         check("missing_transition", {29'd0, dst}, {29'd0, e.dst});
         cur      = e;
         prev_dst = dst;
      end
      check("o_dst", {29'd0, dst}, {29'd0, cur.dst});
      check("o_lit", {31'd0, lit}, {31'd0, cur.lit});
      check("o_miss", {31'd0, miss}, {31'd0, cur.miss});
      check("o_init", {31'd0, init}, {31'd0, cur.init});
      check(bcdmux ? "o_bcd_best" : "o_bcd_last", {8'd0, bcd}, {8'd0, bcdmux ? cur.best : cur.last});
   end

   initial begin
      forever begin
         @(posedge clk);
         #2;
         bcdmux = 1'($urandom);
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic push_model();
      exp_t e;
      e = '{0, m_dst, (m_dst == D_GO), (m_dst == D_MISS), m_init, m_last, m_best};
      e.cyc = cyc + 3;
      q.push_back(e);
   endtask

   // Raise the button now; the transition lands three edges later.
   task automatic do_press(input int hold);
      logic [15:0] l;
      int          p;
      p = cyc + 3;
      case (m_dst)
         D_READY: m_dst = D_MISS;
         D_GO: begin
            m_last = to_bcd((p - 1 - m_go) / T);
            if (m_init || m_last < m_best) m_best = m_last;
            m_init = 1'b0;
            m_dst  = D_HIT;
         end
         default: begin
            l     = lfsr_next(lfsr_next(m_lfsr));
            m_go  = p + T * U * (1000 + int'(l[9:0]));
            m_dst = D_READY;
         end
      endcase
      push_model();
      btn = 1'b1;
      wait_cycles(hold);
      btn = 1'b0;
      wait_cycles(4);
   endtask

   task automatic go_wait();
      exp_t e;
      m_dst = D_GO;
      e = '{m_go, D_GO, 1'b1, 1'b0, m_init, m_last, m_best};
      q.push_back(e);
      wait_until(m_go + 1);
   endtask

   task automatic hit_after(input int x);
      do_press(1 + $urandom_range(0, 3));
      go_wait();
      wait_until(m_go + x);
      do_press(2);
   endtask

   initial begin
      exp_t e;
      // Reset with the button already held; releasing reset must not count as a press.
      btn   = 1'b1;
      rst_n = 1'b0;
      wait_cycles(4);
      rst_n = 1'b1;
      wait_cycles(12);
      btn = 1'b0;
      wait_cycles(6);

      // Early press 5 ms into READY.
      do_press(2);
      wait_until(cyc + 5 * U * T);
      do_press(2);

      // Hits at 250, 400 and 120 us.
      hit_after(498);
      hit_after(798);
      hit_after(238);

      // Press on the exact cycle the delay expires: early press wins.
      do_press(2);
      wait_until(m_go - 3);
      do_press(2);

      // Randomized rounds of early presses and hits.
      for (int r = 0; r < 5; r++) begin
         if ($urandom_range(0, 2) == 0) begin
            do_press(1 + $urandom_range(0, 3));
            wait_until(cyc + $urandom_range(1, m_go - cyc - 8));
            do_press(2);
         end else begin
            hit_after($urandom_range(1, 3000));
         end
      end

      // Stopwatch overflow: timer wraps out at 999999 us into MISS.
      do_press(2);
      go_wait();
      m_dst = D_MISS;
      e = '{m_go + T * 1000000, D_MISS, 1'b0, 1'b1, m_init, m_last, m_best};
      q.push_back(e);
      wait_until(m_go + T * 1000000 + 2);

      // Reset in the middle of GO discards everything.
      do_press(2);
      go_wait();
      wait_cycles(100);
      q.delete();
      rst_n  = 1'b0;
      m_dst  = D_IDLE;
      m_last = 24'h0;
      m_best = 24'h0;
      m_init = 1'b1;
      wait_cycles(3);
      rst_n = 1'b1;
      wait_cycles(6);

      // First hit after reset sets best unconditionally.
      hit_after(1500);
      wait_cycles(10);

      check("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
